sharpen_stream_ctrl: RTL and testbench
======================================

SHARPEN_STREAM_CTRL -- requirements
Module: sharpen_stream_ctrl

Interface
REQ-001 The module SHALL have parameter IMG_WIDTH, default 320, pixels per row.
REQ-002 The module SHALL have parameter IMG_HEIGHT, default 240, rows per frame.
REQ-003 The module SHALL have parameter FLUSH_CYCLES, default 2*IMG_WIDTH+4, idle cycles after the last pixel so the filter pipeline drains.
REQ-004 The module SHALL have parameter ROW_GAP, default 4, idle cycles inserted between rows when the row-gap feature is compiled in.
REQ-005 The module SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The module SHALL have port start, input, 1, one-cycle frame request, sampled only in IDLE.
REQ-008 The module SHALL have port abort, input, 1, cancels the frame in progress.
REQ-009 The module SHALL have port stall, input, 1, frame-buffer read port is unavailable this cycle.
REQ-010 The module SHALL have port rd_en, output, 1, frame-buffer read strobe.
REQ-011 The module SHALL have port rAddr, output, 17, frame-buffer read address.
REQ-012 The module SHALL have port rData, input, 16, RGB565 read data, valid exactly one cycle after rd_en.
REQ-013 The module SHALL have ports we_out / wAddr_out / wData_out, output, 1 / 17 / 16, the pixel stream to the sharpen filter's we_in / wAddr_in / wData_in.
REQ-014 The module SHALL have ports busy, output, 1 (high outside IDLE), and done, output, 1 (one-cycle completion pulse).

Function
REQ-015 The block SHALL implement states IDLE, READ, GAP, FLUSH and DONE.
REQ-016 In IDLE with start=1, the block SHALL go to READ next cycle with its pixel counter=0 and its row/column counters=0.
REQ-017 In READ with stall=0, the block SHALL assert rd_en with rAddr=pixel counter, then increment the counter; column wraps at IMG_WIDTH-1 to 0 with row+1.
REQ-018 In READ with stall=1, the block SHALL hold rd_en=0 and freeze all counters; an already-issued read still completes.
REQ-019 The block SHALL drive we_out=1, wAddr_out=rAddr of the previous cycle and wData_out=rData exactly one cycle after each rd_en; fixed latency is 1, and there are no gaps other than those caused by stall/GAP.
REQ-020 After the read of address IMG_WIDTH*IMG_HEIGHT-1, the block SHALL go to FLUSH; we_out for that last pixel still fires in the first FLUSH cycle.
REQ-021 FLUSH SHALL last exactly FLUSH_CYCLES cycles with we_out=0 (except per REQ-020), then go to DONE.
REQ-022 DONE SHALL last one cycle with done=1 and busy=1, then go to IDLE.
REQ-023 A start received outside IDLE SHALL be ignored, with no queuing.
REQ-024 abort=1 in any non-IDLE state SHALL send the block to IDLE next cycle with rd_en=0, no done pulse and counters cleared; a write for a read issued in the abort cycle is suppressed (we_out=0).
REQ-025 abort has priority over stall, and stall has priority over counter advance.
REQ-026 wAddr_out and wData_out SHALL hold their last values when we_out=0.

Reset
REQ-027 While reset=0 the block SHALL be in IDLE with rd_en=0, rAddr=0, we_out=0, wAddr_out=0, wData_out=0, busy=0, done=0 and all counters 0.
REQ-028 Deassertion of reset SHALL take effect at the next rising clk edge; reset mid-frame discards the frame without a done pulse.

Configuration
REQ-029 With macro SHARPEN_CTRL_ROWGAP_EN defined, after the last column of each row except the final row, READ SHALL go to GAP for ROW_GAP cycles (rd_en=0, stall ignored), then return to READ.
REQ-030 Without SHARPEN_CTRL_ROWGAP_EN, the GAP state SHALL NOT exist and rows SHALL be read back-to-back.

Verification
REQ-031 Reset/idle: reset=0 for 3 cycles, release, no start -> all outputs 0, busy=0 for 20 cycles.
REQ-032 Full frame, IMG 8x8, FLUSH_CYCLES=20, no stall, macro off: start -> rd_en for 64 consecutive cycles with rAddr 0..63; we_out 64 cycles lagging by 1 with wData_out=rData; done pulses 1+64+20 cycles after start; busy falls the cycle after done.
REQ-033 Stall: 8x8 frame with stall=1 for 3 cycles after the read of addr 10 -> rd_en low 3 cycles, next rAddr=11, no address skipped or repeated, and done delayed by exactly 3 cycles.
REQ-034 Abort: abort=1 in the cycle rd_en reads addr 30 -> IDLE next cycle, we_out=0 thereafter, no done; a new start then restarts at rAddr=0.
REQ-035 Start ignored: a second start pulse during READ and during FLUSH -> exactly one done per frame, with unchanged timing.
REQ-036 Row gap: macro on, ROW_GAP=4, 8x8 frame -> 7 gaps of 4 idle cycles after rAddr 7, 15, ..., 55, none after 63; done is delayed by 28 cycles versus REQ-032.

Source files
------------

// File: rtl/sharpen_stream_ctrl.sv
// rtl/sharpen_stream_ctrl.sv - frame-buffer reader feeding the sharpen filter pixel stream.
// Define SHARPEN_CTRL_ROWGAP_EN to insert ROW_GAP idle cycles between rows.
module sharpen_stream_ctrl #(
  parameter int IMG_WIDTH    = 320,
  parameter int IMG_HEIGHT   = 240,
  parameter int FLUSH_CYCLES = 2*IMG_WIDTH+4,
  parameter int ROW_GAP      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        stall,
  output logic        rd_en,
  output logic [16:0] rAddr,
  input  logic [15:0] rData,
  output logic        we_out,
  output logic [16:0] wAddr_out,
  output logic [15:0] wData_out,
  output logic        busy,
  output logic        done
);

  localparam int CW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int WMAX = (FLUSH_CYCLES > ROW_GAP) ? FLUSH_CYCLES : ROW_GAP;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [16:0] LAST_PIX = 17'(IMG_WIDTH*IMG_HEIGHT - 1);

`ifdef SHARPEN_CTRL_ROWGAP_EN
  typedef enum logic [2:0] {IDLE, READ, FLUSH, DONE, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, FLUSH, DONE} state_t;
`endif

  state_t          state;
  logic [16:0]     pixCnt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [WW-1:0]   waitCnt;
  logic [15:0]     heldData;

  // The read strobe reacts to stall in the same cycle so a stalled cycle never issues a read.
  assign rd_en     = (state == READ) && !stall;
  assign rAddr     = pixCnt;
  assign wData_out = we_out ? rData : heldData;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pixCnt    <= '0;
      col       <= '0;
      row       <= '0;
      waitCnt   <= '0;
      we_out    <= 1'b0;
      wAddr_out <= '0;
      heldData  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      we_out <= rd_en && !abort;
      if (rd_en && !abort) wAddr_out <= rAddr;
      if (we_out) heldData <= rData;
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        pixCnt  <= '0;
        col     <= '0;
        row     <= '0;
        waitCnt <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state  <= READ;
            busy   <= 1'b1;
            pixCnt <= '0;
            col    <= '0;
            row    <= '0;
          end
          READ: if (!stall) begin
            if (pixCnt == LAST_PIX) begin
              state   <= FLUSH;
              pixCnt  <= '0;
              col     <= '0;
              row     <= '0;
              waitCnt <= '0;
            end else begin
              pixCnt <= pixCnt + 17'd1;
              if (col == CW'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= row + 1'b1;
`ifdef SHARPEN_CTRL_ROWGAP_EN
                if (ROW_GAP > 0) begin
                  state   <= GAP;
                  waitCnt <= '0;
                end
`endif
              end else begin
                col <= col + 1'b1;
              end
            end
          end
`ifdef SHARPEN_CTRL_ROWGAP_EN
          GAP: if (waitCnt == WW'(ROW_GAP - 1)) begin
            state   <= READ;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
          FLUSH: if (waitCnt == WW'(FLUSH_CYCLES - 1)) begin
            state   <= DONE;
            done    <= 1'b1;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sharpen_stream_ctrl.sv
// tb/tb_sharpen_stream_ctrl.sv - directed table and frame-sequence bench for sharpen_stream_ctrl.
module tb_sharpen_stream_ctrl;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int FL = 20;
  localparam int RG = 4;
`ifdef SHARPEN_CTRL_ROWGAP_EN
  localparam int GAPS   = (H - 1) * RG;
  localparam bit ROWGAP = 1'b1;
`else
  localparam int GAPS   = 0;
  localparam bit ROWGAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        stall = 1'b0;
  logic        rd_en;
  logic [16:0] rAddr;
  logic [15:0] rData;
  logic        we_out;
  logic [16:0] wAddr_out;
  logic [15:0] wData_out;
  logic        busy;
  logic        done;

  int compared = 0;
  int mismatched = 0;

  sharpen_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FLUSH_CYCLES(FL), .ROW_GAP(RG)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
    .rd_en(rd_en), .rAddr(rAddr), .rData(rData),
    .we_out(we_out), .wAddr_out(wAddr_out), .wData_out(wData_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input logic [16:0] a);
    return a[15:0] * 16'd773;
  endfunction

  // Frame-buffer model: data for the address read last cycle, junk otherwise.
  logic        rdPrev = 1'b0;
  logic [16:0] addrPrev = '0;
  always @(posedge clk) begin
    rdPrev   <= rd_en;
    addrPrev <= rAddr;
  end
  assign rData = rdPrev ? pix(addrPrev) : 16'hBEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic st, sl, ab;
    logic rd; logic [16:0] ra; logic we; logic [16:0] wa; logic bz, dn;
  } vec_t;
  vec_t vt[13];

  task automatic runFrame(input string tag, input bit useStall, input bit extraStart);
    int expDone, reads, dones, doneAt, idleRun, stallLeft, expGap;
    bit prevRd;
    logic [16:0] prevA;
    expDone = 1 + W*H + FL + GAPS + (useStall ? 3 : 0);
    reads = 0; dones = 0; doneAt = -1; idleRun = 0; stallLeft = 0;
    prevRd = 1'b0; prevA = '0;
    for (int c = 0; c <= expDone + 3; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (extraStart && (c == 20 || c == expDone - 5));
      stall = (stallLeft > 0);
      if (stallLeft > 0) stallLeft--;
      @(negedge clk);
      check({tag, "_busy"}, 64'(busy), 64'(c >= 1 && c <= expDone));
      check({tag, "_we"}, 64'(we_out), 64'(prevRd));
      if (we_out && prevRd) begin
        check({tag, "_waddr"}, 64'(wAddr_out), 64'(prevA));
        check({tag, "_wdata"}, 64'(wData_out), 64'(pix(prevA)));
      end
      if (done) begin
        dones++;
        doneAt = c;
      end
      if (rd_en) begin
        check({tag, "_raddr"}, 64'(rAddr), 64'(reads));
        if (reads > 0) begin
          expGap = ((useStall && reads - 1 == 10) ? 3 : 0) +
                   ((ROWGAP && ((reads - 1) % W) == W - 1) ? RG : 0);
          check({tag, "_gap"}, 64'(idleRun), 64'(expGap));
        end
        if (useStall && rAddr == 17'd10) stallLeft = 3;
        reads++;
        idleRun = 0;
      end else if (reads > 0) begin
        idleRun++;
      end
      prevRd = rd_en;
      prevA  = rAddr;
    end
    start = 1'b0;
    stall = 1'b0;
    check({tag, "_reads"}, 64'(reads), 64'(W*H));
    check({tag, "_dones"}, 64'(dones), 64'd1);
    check({tag, "_done_at"}, 64'(doneAt), 64'(expDone));
  endtask

  initial begin
    // reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {rd_en, rAddr, we_out, wAddr_out, wData_out, busy, done}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_outs", {rd_en, rAddr, we_out, wAddr_out, wData_out, busy, done}, 64'd0);
    end

    // start / stall / ignored start / abort corner vectors
    vt[0]  = '{1,0,0, 0,0,0,0,0,0};
    vt[1]  = '{0,0,0, 1,0,0,0,1,0};
    vt[2]  = '{0,0,0, 1,1,1,0,1,0};
    vt[3]  = '{0,1,0, 0,2,1,1,1,0};
    vt[4]  = '{0,0,0, 1,2,0,1,1,0};
    vt[5]  = '{1,0,0, 1,3,1,2,1,0};
    vt[6]  = '{0,0,1, 1,4,1,3,1,0};
    vt[7]  = '{0,0,0, 0,0,0,3,0,0};
    vt[8]  = '{0,0,0, 0,0,0,3,0,0};
    vt[9]  = '{1,0,0, 0,0,0,3,0,0};
    vt[10] = '{0,0,0, 1,0,0,3,1,0};
    vt[11] = '{0,1,1, 0,1,1,0,1,0};
    vt[12] = '{0,0,0, 0,0,0,0,0,0};
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      start = vt[i].st; stall = vt[i].sl; abort = vt[i].ab;
      @(negedge clk);
      check($sformatf("vec%0d_rd", i), 64'(rd_en), 64'(vt[i].rd));
      check($sformatf("vec%0d_raddr", i), 64'(rAddr), 64'(vt[i].ra));
      check($sformatf("vec%0d_we", i), 64'(we_out), 64'(vt[i].we));
      check($sformatf("vec%0d_waddr", i), 64'(wAddr_out), 64'(vt[i].wa));
      check($sformatf("vec%0d_wdata", i), 64'(wData_out), 64'(pix(vt[i].wa)));
      check($sformatf("vec%0d_busy_done", i), {busy, done}, {vt[i].bz, vt[i].dn});
    end
    @(posedge clk); #1;
    start = 1'b0; stall = 1'b0; abort = 1'b0;

    runFrame("full", 1'b0, 1'b0);
    runFrame("stall", 1'b1, 1'b0);
    runFrame("restart", 1'b0, 1'b1);

    // abort on the read of address 30
    for (int c = 0; c <= 31; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      abort = (c == 31);
      @(negedge clk);
    end
    check("abort_cycle_read", {rd_en, rAddr}, {1'b1, 17'd30});
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {rd_en, rAddr, busy}, {1'b0, 17'd0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_quiet", {we_out, done, busy, rd_en}, 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_restart", {rd_en, rAddr, busy}, {1'b1, 17'd0, 1'b1});
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_final_idle", {busy, rd_en}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
